servo_pwm_bank: RTL and testbench
=================================

Name: servo_pwm_bank

Overview:
- Parametrised multi-channel hobby-servo PWM generator for the sorter/dispenser FPGA.
- Replaces the fixed per-servo pulse code with one block.
- A shared 20 ms frame timer drives CHANNELS independent channels.
- Each channel accepts a "go to width W for F frames, then rest G frames" command through a valid/ready handshake and reports busy/done back to the MBED-facing logic.

Parameters:
- CHANNELS, 4, number of servo outputs (1..16)
- FRAME_TICKS, 1000000, clk ticks per PWM frame (20 ms at 50 MHz)
- WIDTH_W, 17, bits of pulse-width field, in ticks
- FRAMES_W, 8, bits of frame-count field
- MIN_WIDTH, 50000, lower clamp on commanded width (1 ms)
- MAX_WIDTH, 100000, upper clamp on commanded width (2 ms)
- GAP_FRAMES, 50, rest frames after a finite command
- RAMP_STEP, 1000, ticks of width change per frame (only with ramp feature)

Ports:
- clk, input, 1, 50 MHz system clock
- rst, input, 1, asynchronous active-high reset
- cmd_valid, input, 1, command present
- cmd_ready, output, 1, command can be accepted this cycle
- cmd_chan, input, clog2(CHANNELS) min 1, target channel
- cmd_width, input, WIDTH_W, pulse high time in ticks
- cmd_frames, input, FRAMES_W, frames to drive; 0 = hold continuously
- cmd_err, output, 1, one-cycle pulse: command to out-of-range channel was dropped
- pwm, output, CHANNELS, servo pulse outputs
- busy, output, CHANNELS, channel has a pending, driving or resting finite command
- done, output, CHANNELS, one-cycle pulse when a channel returns to IDLE from REST
- frame_start, output, 1, one-cycle pulse when the frame counter is 0

Behaviour:
- Reset (async, rst=1) sets:
  - frame counter = 0
  - all channels IDLE, pending cleared
  - pwm = 0, busy = 0, done = 0, cmd_err = 0, frame_start = 0
- Frame counter:
  - Counts 0..FRAME_TICKS-1, then wraps to 0.
  - frame_start is registered and high for exactly the cycle in which the counter equals 0.
- Handshake:
  - cmd_ready = !busy[cmd_chan], combinational from registered state.
  - cmd_ready = 1 when cmd_chan >= CHANNELS.
  - A transfer occurs when cmd_valid && cmd_ready.
  - Out-of-range transfer: dropped; cmd_err pulses the next cycle.
- Accept:
  - Width is clamped to [MIN_WIDTH, MAX_WIDTH] and latched into the channel's pending slot with its frame count.
  - busy rises the next cycle for finite commands (frames != 0).
  - Continuous commands (frames = 0) never assert busy, so a HOLD channel can be retargeted at any time.
  - A new command on a HOLD channel overwrites pending.
- Channel FSM, states IDLE, HOLD, DRIVE, REST:
  - Transitions happen only on frame_start (no truncated or stretched pulses).
  - IDLE/HOLD with pending finite -> DRIVE: load width, frames_left = F.
  - IDLE/HOLD with pending continuous -> HOLD: load width.
  - DRIVE: frames_left decrements at each frame_start; when it reaches 0 at a frame_start -> REST with gap_left = GAP_FRAMES.
  - REST: gap_left decrements per frame; at 0 -> IDLE, done pulses for 1 cycle.
  - GAP_FRAMES = 0 goes DRIVE -> IDLE directly, and done still pulses.
- Outputs:
  - pwm[i] = 1 when state is DRIVE or HOLD and frame counter < active width; otherwise 0.
  - pwm is registered, so it lags the counter by one cycle.
  - A finite command of F frames yields exactly F high pulses.
- Reset mid-operation aborts everything immediately: pwm goes low asynchronously and pending commands are lost.
- Simultaneous events: accept and frame_start in the same cycle means the command waits for the next frame_start.

Optional Feature:
- Macro SERVO_RAMP_EN.
- When defined:
  - On each frame_start in DRIVE/HOLD, the active width moves toward the target by at most RAMP_STEP ticks, reaching the target exactly without overshoot.
  - A DRIVE command does not begin counting frames_left until the target is reached.
  - The active width persists through IDLE as the ramp origin; it resets to MIN_WIDTH.
- When undefined: the active width jumps to the target at the first frame_start.

Decomposition:
- Package servo_pkg holds:
  - the channel state enum (IDLE, HOLD, DRIVE, REST)
  - default FRAME_TICKS, MIN_WIDTH and MAX_WIDTH constants
  - a clamp function
- One sub-module, servo_chan, contains the per-channel FSM, pending slot, counters and pwm compare.
- The top level generates CHANNELS instances and owns the frame counter and handshake decode.

Test Plan:
- Reset: hold rst mid-frame with a channel in DRIVE -> pwm = 0, busy = 0 immediately; after release, frame_start first occurs with counter 0.
- Finite command: chan 1, width 73000, frames 3 -> three pulses of exactly 73000 cycles starting at the next frame_start; busy stays high through 50 REST frames, then done pulses once.
- Clamp: width 20000 -> 50000-cycle pulses; width 120000 -> 100000-cycle pulses.
- Handshake: a second command to chan 1 while busy -> cmd_ready = 0 and the command is held; the same cycle to chan 2 -> accepted.
- Continuous: frames 0, width 95000 -> busy stays 0; a new width of 50000 takes effect at the next frame boundary with no partial pulse.
- cmd_chan = CHANNELS -> accepted, cmd_err one cycle, no pwm change; with SERVO_RAMP_EN, 50000 -> 55000 with RAMP_STEP 1000 gives widths 51000..55000 over 5 frames.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared types and defaults for the servo PWM bank: channel state encoding,
// 50 MHz frame/width defaults and the command width clamp.
package servo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    DRIVE = 2'd2,
    REST  = 2'd3
  } chan_state_e;

  localparam int DEF_FRAME_TICKS = 1000000;
  localparam int DEF_MIN_WIDTH   = 50000;
  localparam int DEF_MAX_WIDTH   = 100000;

  function automatic int unsigned clamp_width(input int unsigned w,
                                              input int unsigned lo,
                                              input int unsigned hi);
    if (w < lo) return lo;
    if (w > hi) return hi;
    return w;
  endfunction

endpackage

// File: rtl/servo_chan.sv
// One servo channel: pending command slot, IDLE/HOLD/DRIVE/REST sequencer and
// registered pwm compare. SERVO_RAMP_EN limits width slew to RAMP_STEP per frame.
module servo_chan
  import servo_pkg::*;
#(
  parameter int CNT_W      = 20,
  parameter int WIDTH_W    = 17,
  parameter int FRAMES_W   = 8,
  parameter int MIN_WIDTH  = DEF_MIN_WIDTH,
  parameter int GAP_FRAMES = 50,
  parameter int RAMP_STEP  = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_start,
  input  logic [CNT_W-1:0]    cnt,
  input  logic                acc,
  input  logic [WIDTH_W-1:0]  acc_width,
  input  logic [FRAMES_W-1:0] acc_frames,
  output logic                pwm,
  output logic                busy,
  output logic                done
);

  localparam int GAP_W = $clog2(GAP_FRAMES + 2);
`ifdef SERVO_RAMP_EN
  localparam bit RAMP_EN = 1'b1;
`else
  localparam bit RAMP_EN = 1'b0;
`endif
  // Without ramping the step covers the whole width range, i.e. a jump.
  localparam longint STEP = RAMP_EN ? longint'(RAMP_STEP) : (longint'(1) << WIDTH_W);

  chan_state_e         state_q, state_d;
  logic                pend_vld_q, pend_vld_d;
  logic [WIDTH_W-1:0]  pend_width_q, pend_width_d;
  logic [FRAMES_W-1:0] pend_frames_q, pend_frames_d;
  logic [WIDTH_W-1:0]  tgt_q, tgt_d;
  logic [WIDTH_W-1:0]  act_q, act_d;
  logic [FRAMES_W-1:0] frames_left_q, frames_left_d;
  logic [GAP_W-1:0]    gap_left_q, gap_left_d;
  logic                pwm_q, pwm_d;
  logic                done_q, done_d;

  function automatic logic [WIDTH_W-1:0] step_to(input logic [WIDTH_W-1:0] cur,
                                                 input logic [WIDTH_W-1:0] tgt);
    longint c, t;
    c = longint'(cur);
    t = longint'(tgt);
    if (t > c + STEP) return WIDTH_W'(c + STEP);
    if (c > t + STEP) return WIDTH_W'(c - STEP);
    return tgt;
  endfunction

  always_comb begin
    state_d       = state_q;
    pend_vld_d    = pend_vld_q;
    pend_width_d  = pend_width_q;
    pend_frames_d = pend_frames_q;
    tgt_d         = tgt_q;
    act_d         = act_q;
    frames_left_d = frames_left_q;
    gap_left_d    = gap_left_q;
    done_d        = 1'b0;

    if (acc) begin
      pend_vld_d    = 1'b1;
      pend_width_d  = acc_width;
      pend_frames_d = acc_frames;
    end

    // Pending is consumed from the registered slot, so a command accepted on
    // a frame_start cycle waits for the following frame.
    if (frame_start) begin
      unique case (state_q)
        IDLE, HOLD: begin
          if (pend_vld_q) begin
            if (!acc) pend_vld_d = 1'b0;
            tgt_d         = pend_width_q;
            act_d         = step_to(act_q, pend_width_q);
            frames_left_d = pend_frames_q;
            state_d       = (pend_frames_q != '0) ? DRIVE : HOLD;
          end else if (state_q == HOLD) begin
            act_d = step_to(act_q, tgt_q);
          end
        end
        DRIVE: begin
          // Only frames driven at the target width count toward F.
          if (act_q != tgt_q) begin
            act_d = step_to(act_q, tgt_q);
          end else if (frames_left_q > FRAMES_W'(1)) begin
            frames_left_d = frames_left_q - FRAMES_W'(1);
          end else if (GAP_FRAMES == 0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d    = REST;
            gap_left_d = GAP_W'(GAP_FRAMES);
          end
        end
        REST: begin
          if (gap_left_q > GAP_W'(1)) begin
            gap_left_d = gap_left_q - GAP_W'(1);
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Compare against next-state width so the counter-0 tick is included.
    pwm_d = ((state_d == DRIVE) || (state_d == HOLD)) && (32'(cnt) < 32'(act_d));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pend_vld_q    <= 1'b0;
      pend_width_q  <= '0;
      pend_frames_q <= '0;
      tgt_q         <= WIDTH_W'(MIN_WIDTH);
      act_q         <= WIDTH_W'(MIN_WIDTH);
      frames_left_q <= '0;
      gap_left_q    <= '0;
      pwm_q         <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_vld_q    <= pend_vld_d;
      pend_width_q  <= pend_width_d;
      pend_frames_q <= pend_frames_d;
      tgt_q         <= tgt_d;
      act_q         <= act_d;
      frames_left_q <= frames_left_d;
      gap_left_q    <= gap_left_d;
      pwm_q         <= pwm_d;
      done_q        <= done_d;
    end
  end

  assign pwm  = pwm_q;
  assign done = done_q;
  assign busy = (pend_vld_q && (pend_frames_q != '0)) || (state_q == DRIVE) || (state_q == REST);

endmodule

// File: rtl/servo_pwm_bank.sv
// Multi-channel servo PWM bank: shared frame counter, command handshake decode
// and an array of servo_chan instances. SERVO_RAMP_EN enables width ramping.
module servo_pwm_bank
  import servo_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int FRAME_TICKS = DEF_FRAME_TICKS,
  parameter int WIDTH_W     = 17,
  parameter int FRAMES_W    = 8,
  parameter int MIN_WIDTH   = DEF_MIN_WIDTH,
  parameter int MAX_WIDTH   = DEF_MAX_WIDTH,
  parameter int GAP_FRAMES  = 50,
  parameter int RAMP_STEP   = 1000,
  localparam int CHAN_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [CHAN_W-1:0]   cmd_chan,
  input  logic [WIDTH_W-1:0]  cmd_width,
  input  logic [FRAMES_W-1:0] cmd_frames,
  output logic                cmd_err,
  output logic [CHANNELS-1:0] pwm,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] done,
  output logic                frame_start
);

  localparam int CNT_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam int SEL_W = 1 << CHAN_W;

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                frame_start_q, frame_start_d;
  logic                cmd_err_q, cmd_err_d;
  logic                in_range, xfer;
  logic [SEL_W-1:0]    busy_ext;
  logic [WIDTH_W-1:0]  width_clamped;
  logic [CHANNELS-1:0] acc;

  // Unused channel codes read as not-busy, so out-of-range commands are ready.
  assign busy_ext  = SEL_W'(busy);
  assign cmd_ready = ~busy_ext[cmd_chan];
  assign in_range  = 32'(cmd_chan) < 32'(CHANNELS);
  assign xfer      = cmd_valid & cmd_ready;
  assign width_clamped = WIDTH_W'(clamp_width(32'(cmd_width), MIN_WIDTH, MAX_WIDTH));

  always_comb begin
    cnt_d         = (cnt_q == CNT_W'(FRAME_TICKS - 1)) ? '0 : cnt_q + CNT_W'(1);
    frame_start_d = (cnt_d == '0);
    cmd_err_d     = xfer & ~in_range;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      frame_start_q <= 1'b0;
      cmd_err_q     <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      frame_start_q <= frame_start_d;
      cmd_err_q     <= cmd_err_d;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_acc
    assign acc[i] = xfer && (cmd_chan == CHAN_W'(i));
  end

  servo_chan #(
    .CNT_W      (CNT_W),
    .WIDTH_W    (WIDTH_W),
    .FRAMES_W   (FRAMES_W),
    .MIN_WIDTH  (MIN_WIDTH),
    .GAP_FRAMES (GAP_FRAMES),
    .RAMP_STEP  (RAMP_STEP)
  ) u_chan [CHANNELS-1:0] (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start_q),
    .cnt         (cnt_q),
    .acc         (acc),
    .acc_width   (width_clamped),
    .acc_frames  (cmd_frames),
    .pwm         (pwm),
    .busy        (busy),
    .done        (done)
  );

  assign frame_start = frame_start_q;
  assign cmd_err     = cmd_err_q;

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Directed bench for servo_pwm_bank on a scaled-down frame (200 ticks, widths 50..100).
module tb_servo_pwm_bank;

  localparam int CH = 3, FT = 200, WW = 17, FW = 8, MINW = 50, MAXW = 100, GAP = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid, cmd_ready, cmd_err, frame_start;
  logic [1:0]    cmd_chan;
  logic [WW-1:0] cmd_width;
  logic [FW-1:0] cmd_frames;
  logic [CH-1:0] pwm, busy, done;

  always #5 clk = ~clk;

  servo_pwm_bank #(
    .CHANNELS(CH), .FRAME_TICKS(FT), .WIDTH_W(WW), .FRAMES_W(FW),
    .MIN_WIDTH(MINW), .MAX_WIDTH(MAXW), .GAP_FRAMES(GAP), .RAMP_STEP(1000)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_chan(cmd_chan), .cmd_width(cmd_width), .cmd_frames(cmd_frames),
    .cmd_err(cmd_err), .pwm(pwm), .busy(busy), .done(done), .frame_start(frame_start)
  );

`ifdef SERVO_RAMP_EN
  logic          r_valid, r_ready, r_err, r_fs;
  logic [0:0]    r_chan, r_pwm, r_busy, r_done;
  logic [WW-1:0] r_width;
  logic [FW-1:0] r_frames;

  servo_pwm_bank #(
    .CHANNELS(1), .FRAME_TICKS(FT), .WIDTH_W(WW), .FRAMES_W(FW),
    .MIN_WIDTH(MINW), .MAX_WIDTH(MAXW), .GAP_FRAMES(GAP), .RAMP_STEP(1)
  ) u_ramp (
    .clk(clk), .rst(rst), .cmd_valid(r_valid), .cmd_ready(r_ready),
    .cmd_chan(r_chan), .cmd_width(r_width), .cmd_frames(r_frames),
    .cmd_err(r_err), .pwm(r_pwm), .busy(r_busy), .done(r_done), .frame_start(r_fs)
  );
`else
  logic r_pwm;
  assign r_pwm = 1'b0;
`endif

  // Pulse-length monitor: channel 3 is the ramp instance.
  logic [3:0] mon;
  assign mon = {r_pwm, pwm};
  int run [4];
  int npulse [4];
  int sum_len [4];
  int last_len [4];
  int ndone [3];

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mon[i]) run[i]++;
      else if (run[i] > 0) begin
        npulse[i]++;
        sum_len[i] += run[i];
        last_len[i] = run[i];
        run[i] = 0;
      end
    end
    for (int i = 0; i < 3; i++) if (done[i]) ndone[i]++;
  end

  int errors = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_fs(input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while (!frame_start && n < 2 * FT);
    if (!frame_start) chk(tag, 32'(frame_start), 1);
  endtask

  task automatic wait_done(input int ch);
    int n = 0;
    while (!done[ch] && n < 3000) begin @(negedge clk); n++; end
    chk($sformatf("done%0d_seen", ch), 32'(done[ch]), 1);
  endtask

  task automatic send(input logic [1:0] ch, input int w, input int f);
    cmd_chan = ch; cmd_width = WW'(w); cmd_frames = FW'(f); cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    int np0, np1, np2, sl0, sl1, sl2, nd0, nd1, nd2, n;
    cmd_valid = 1'b0; cmd_chan = '0; cmd_width = '0; cmd_frames = '0;
`ifdef SERVO_RAMP_EN
    r_valid = 1'b0; r_chan = '0; r_width = '0; r_frames = '0;
`endif
    cyc(3);
    chk("rst_pwm", 32'(pwm), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_frame_start", 32'(frame_start), 0);
    chk("rst_cmd_err", 32'(cmd_err), 0);
    chk("rst_ready", 32'(cmd_ready), 1);
    rst = 1'b0;

    // Finite commands plus clamping; all start on the first frame_start.
    np0 = npulse[0]; np1 = npulse[1]; np2 = npulse[2];
    sl0 = sum_len[0]; sl1 = sum_len[1]; sl2 = sum_len[2];
    nd0 = ndone[0]; nd1 = ndone[1]; nd2 = ndone[2];
    send(1, 73, 3);
    chk("busy1_rise", 32'(busy[1]), 1);
    cmd_chan = 2'd1; cmd_width = WW'(60); cmd_frames = FW'(1); cmd_valid = 1'b1;
    #1 chk("held_ready", 32'(cmd_ready), 0);
    cyc(3);
    chk("held_ready_still", 32'(cmd_ready), 0);
    cmd_chan = 2'd2; cmd_width = WW'(20); cmd_frames = FW'(2);
    #1 chk("ch2_ready", 32'(cmd_ready), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("busy2_rise", 32'(busy[2]), 1);
    send(0, 120, 1);
    chk("busy0_rise", 32'(busy[0]), 1);

    wait_done(0);
    chk("busy0_clear", 32'(busy[0]), 0);
    chk("busy1_in_rest", 32'(busy[1]), 1);
    chk("ch0_npulse", 32'(npulse[0] - np0), 1);
    chk("ch0_clamp_max", 32'(last_len[0]), 100);
    wait_done(2);
    chk("ch2_npulse", 32'(npulse[2] - np2), 2);
    chk("ch2_clamp_min_sum", 32'(sum_len[2] - sl2), 100);
    wait_done(1);
    chk("busy1_clear", 32'(busy[1]), 0);
    chk("ch1_npulse", 32'(npulse[1] - np1), 3);
    chk("ch1_sum", 32'(sum_len[1] - sl1), 219);
    chk("ch1_last", 32'(last_len[1]), 73);
    @(negedge clk);
    chk("done1_one_cycle", 32'(done[1]), 0);
    cyc(2);
    chk("ndone0", 32'(ndone[0] - nd0), 1);
    chk("ndone1", 32'(ndone[1] - nd1), 1);
    chk("ndone2", 32'(ndone[2] - nd2), 1);

    // Continuous hold and retarget mid-pulse.
    np0 = npulse[0]; sl0 = sum_len[0];
    send(0, 95, 0);
    chk("hold_not_busy", 32'(busy[0]), 0);
    wait_fs("hold_fs1");
    cyc(30);
    chk("hold_pwm_high", 32'(pwm[0]), 1);
    send(0, 50, 0);
    chk("hold_retarget_not_busy", 32'(busy[0]), 0);
    wait_fs("hold_fs2");
    chk("hold_first_len", 32'(last_len[0]), 95);
    chk("hold_first_n", 32'(npulse[0] - np0), 1);
    cyc(120);
    chk("hold_new_len", 32'(last_len[0]), 50);
    chk("hold_no_partial", 32'(sum_len[0] - sl0), 145);

    // Out-of-range channel.
    np1 = npulse[1]; np2 = npulse[2];
    cmd_chan = 2'd3; cmd_width = WW'(70); cmd_frames = FW'(2); cmd_valid = 1'b1;
    #1 chk("oor_ready", 32'(cmd_ready), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("oor_err", 32'(cmd_err), 1);
    chk("oor_busy", 32'(busy), 0);
    @(negedge clk);
    chk("oor_err_pulse", 32'(cmd_err), 0);
    wait_fs("oor_fs");
    cyc(120);
    chk("oor_hold_len", 32'(last_len[0]), 50);
    chk("oor_no_pulses", 32'((npulse[1] - np1) + (npulse[2] - np2)), 0);

    // Accept on a frame_start cycle waits a full frame.
    wait_fs("sim_fs1");
    send(2, 60, 1);
    cyc(10);
    chk("sim_waits", 32'(pwm[2]), 0);
    wait_fs("sim_fs2");
    cyc(10);
    chk("sim_drives", 32'(pwm[2]), 1);

    // Asynchronous reset mid-drive with a pending finite command.
    send(1, 80, 4);
    chk("pre_rst_busy", 32'(busy[2:1]), 3);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_pwm", 32'(pwm), 0);
    chk("rst_async_busy", 32'(busy), 0);
    cyc(3);
    rst = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!frame_start && n < 1000);
    chk("fs_after_rst", 32'(n), FT);
    cyc(10);
    chk("post_rst_pwm", 32'(pwm), 0);
    chk("post_rst_busy", 32'(busy), 0);

`ifdef SERVO_RAMP_EN
    r_chan = '0; r_width = WW'(55); r_frames = '0; r_valid = 1'b1;
    @(negedge clk);
    r_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      wait_fs("ramp_fs");
      cyc(100);
      chk($sformatf("ramp_w%0d", k), 32'(last_len[3]), (k < 5) ? 50 + k : 55);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
